tl_input_stage: RTL and testbench
=================================

TL_INPUT_STAGE -- requirements
Module: tl_input_stage

Interface
REQ-001 Parameter CLK_DIV_SEC, default 50000000: clk cycles per 1 s countdown period; even, >= 4.
REQ-002 Parameter SCAN_DIV, default 25000: clk cycles per half-period of the digit-scan clock; >= 1.
REQ-003 Parameter DEB_CYCLES, default 500000: consecutive stable samples required to accept a button or switch level; >= 1.
REQ-004 Parameter LOCK_S, default 30: seconds before automatic lock release (used only when TL_AUTO_RELEASE_EN is defined); >= 1.
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 btn_we  input  1  raw east-west lock push button, active-high, asynchronous to clk.
REQ-008 btn_ns  input  1  raw north-south lock push button, active-high, asynchronous to clk.
REQ-009 sw_c1, sw_c0  input  1 each  raw test-mode switches, asynchronous to clk.
REQ-010 dec  output  1  1 Hz countdown clock for the light controller; rising edge means one second.
REQ-011 scan  output  1  digit-scan clock, 50% duty cycle.
REQ-012 we, ns  output  1 each  lock-direction levels; {we,ns} is never 11.
REQ-013 c1, c0  output  1 each  debounced test-mode levels.

Function
REQ-014 Second counter sc: counts 0..CLK_DIV_SEC-1 and wraps to 0; dec SHALL be registered, equal to 1 while sc >= CLK_DIV_SEC/2, and otherwise 0.
REQ-015 dec rising edges SHALL be exactly CLK_DIV_SEC cycles apart. The first rising edge SHALL occur CLK_DIV_SEC/2 cycles after rst deasserts.
REQ-016 Internal sec_tick SHALL pulse for exactly one cycle on the cycle in which sc wraps from CLK_DIV_SEC-1 to 0.
REQ-017 Scan counter: scan SHALL toggle every SCAN_DIV cycles, giving a period of 2*SCAN_DIV cycles. The scan counter and the second counter SHALL be independent.
REQ-018 Each raw input SHALL pass through a 2-flop synchronizer and then a per-input debounce counter.
REQ-019 Debounce rule: the debounced level SHALL update only after the synchronized value has differed from it for DEB_CYCLES consecutive cycles. Any mismatch-free cycle SHALL clear that input's counter.
REQ-020 Press event: a one-cycle internal pulse on each 0->1 transition of the debounced btn_we or btn_ns.
REQ-021 Lock FSM states FREE {we,ns}=00, WE=10 and NS=01; outputs SHALL be registered directly from the state.
REQ-022 On a we press: FREE->WE, WE->FREE, NS->WE.
REQ-023 On an ns press: FREE->NS, NS->FREE, WE->NS.
REQ-024 If we and ns presses occur in the same cycle, both SHALL be ignored and the state SHALL be unchanged.
REQ-025 Holding a button SHALL produce only one press. Release SHALL produce no event.
REQ-026 c1 and c0 SHALL equal the debounced sw_c1 and sw_c0 levels, with no further logic.

Reset
REQ-027 While rst=1: sc=0, scan counter=0, dec=0, scan=0, state=FREE (we=ns=0), c1=c0=0, all synchronizer flops and debounced levels=0, all debounce counters=0, lock timer=0.
REQ-028 Reset asserted mid-second or mid-debounce SHALL discard all partial counts. No press event SHALL be generated when rst releases while a button is held; the press is recognised only after DEB_CYCLES stable cycles.

Configuration
REQ-029 Macro TL_AUTO_RELEASE_EN is defined: a lock timer SHALL clear on entry to WE or NS and increment on each sec_tick while locked.
REQ-030 With TL_AUTO_RELEASE_EN defined, reaching LOCK_S SHALL force FREE on the same edge. A press on that same cycle SHALL take priority over the release.
REQ-031 With TL_AUTO_RELEASE_EN undefined: no timer SHALL exist, and a lock SHALL be held until it is changed by a press or by rst.

Verification (CLK_DIV_SEC=20, SCAN_DIV=4, DEB_CYCLES=3, LOCK_S=2)
REQ-032 Release rst at cycle 0 -> dec rises at cycles 10, 30, 50 and falls at 20, 40; scan toggles at 4, 8, 12.
REQ-033 Pulse btn_we high for 2 cycles (glitch) -> we stays 0. Hold btn_we for 10 cycles -> {we,ns}=10 exactly 5 cycles after rise (2 synchronizer + 3 debounce), and stays 10 after release.
REQ-034 In state WE, press ns -> {we,ns}=01. Press ns again -> 00. Press we and ns in the same cycle from 00 -> remains 00.
REQ-035 Set sw_c1=1 and sw_c0=1 -> c1=c0=1 after 5 cycles; toggle sw_c0 every 2 cycles -> c0 holds its level.
REQ-036 TL_AUTO_RELEASE_EN defined: lock WE -> returns to 00 on the second sec_tick after entry. Undefined: we=1 holds for 200 cycles.
REQ-037 Assert rst at cycle 15 with we=1 -> we=0 and dec=0 immediately; after release, the first dec rise is 10 cycles later.

Source files
------------

// File: rtl/tl_input_stage.sv
// tl_input_stage: 1 Hz countdown clock, digit-scan clock, and synchronized and debounced lock buttons/test switches.
// Defining TL_AUTO_RELEASE_EN adds a lock timer that frees a held lock after LOCK_S seconds.
module tl_input_stage #(
    parameter int unsigned CLK_DIV_SEC = 50000000,
    parameter int unsigned SCAN_DIV    = 25000,
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned LOCK_S      = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_we,
    input  logic btn_ns,
    input  logic sw_c1,
    input  logic sw_c0,
    output logic dec,
    output logic scan,
    output logic we,
    output logic ns,
    output logic c1,
    output logic c0
);

    localparam int unsigned SC_W  = $clog2(CLK_DIV_SEC);
    localparam int unsigned SD_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned N_IN  = 4;
    localparam int unsigned IN_WE = 0;
    localparam int unsigned IN_NS = 1;
    localparam int unsigned IN_C1 = 2;
    localparam int unsigned IN_C0 = 3;

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(CLK_DIV_SEC - 1);
    localparam logic [SC_W-1:0] SC_HALF = SC_W'(CLK_DIV_SEC / 2);
    localparam logic [SD_W-1:0] SD_LAST = SD_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEB_CYCLES - 1);

    if (CLK_DIV_SEC < 4 || (CLK_DIV_SEC % 2) != 0) begin : g_bad_clk_div
        $error("CLK_DIV_SEC must be even and >= 4");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("SCAN_DIV must be >= 1");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("DEB_CYCLES must be >= 1");
    end
    if (LOCK_S < 1) begin : g_bad_lock_s
        $error("LOCK_S must be >= 1");
    end

    typedef enum logic [1:0] {
        FREE = 2'b00,
        NS   = 2'b01,
        WE   = 2'b10
    } lock_e;

    logic [SC_W-1:0]            sc_q, sc_d;
    logic                       sec_tick;
    logic                       dec_q, dec_d;
    logic [SD_W-1:0]            sd_q, sd_d;
    logic                       scan_q, scan_d;
    logic                       scan_tog;
    logic [N_IN-1:0]            raw;
    logic [N_IN-1:0]            sync1_q, sync1_d;
    logic [N_IN-1:0]            sync2_q, sync2_d;
    logic [N_IN-1:0]            deb_q, deb_d;
    logic [N_IN-1:0][DB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic                       press_we, press_ns;
    logic                       lock_release;
    lock_e                      state_q, state_d;

    // Second counter and countdown clock; dec is registered from sc_d so it tracks sc_q exactly.
    always_comb begin
        sec_tick = (sc_q == SC_LAST);
        sc_d     = sec_tick ? '0 : sc_q + SC_W'(1);
        dec_d    = (sc_d >= SC_HALF);
    end

    always_comb begin
        scan_tog = (sd_q == SD_LAST);
        sd_d     = scan_tog ? '0 : sd_q + SD_W'(1);
        scan_d   = scan_q ^ scan_tog;
    end

    assign raw = {sw_c0, sw_c1, btn_ns, btn_we};

    // A level is accepted on the DEB_CYCLES-th consecutive mismatching sample; any agreeing sample restarts the count.
    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
                end
            end
        end
        press_we = deb_d[IN_WE] & ~deb_q[IN_WE];
        press_ns = deb_d[IN_NS] & ~deb_q[IN_NS];
    end

    always_comb begin
        state_d = state_q;
        if (press_we && !press_ns) begin
            if (state_q == WE) begin
                state_d = FREE;
            end else begin
                state_d = WE;
            end
        end else if (press_ns && !press_we) begin
            if (state_q == NS) begin
                state_d = FREE;
            end else begin
                state_d = NS;
            end
        end else if (lock_release) begin
            state_d = FREE;
        end
    end

`ifdef TL_AUTO_RELEASE_EN
    localparam int unsigned     LT_W    = $clog2(LOCK_S + 1);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOCK_S - 1);

    logic [LT_W-1:0] lock_tmr_q, lock_tmr_d;

    // Release fires on the tick that would bring the timer to LOCK_S; entering a lock restarts it.
    assign lock_release = (state_q != FREE) && sec_tick && (lock_tmr_q == LT_LAST);

    always_comb begin
        lock_tmr_d = lock_tmr_q;
        if (state_d == FREE || state_d != state_q) begin
            lock_tmr_d = '0;
        end else if (sec_tick) begin
            lock_tmr_d = lock_tmr_q + LT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_tmr_q <= '0;
        end else begin
            lock_tmr_q <= lock_tmr_d;
        end
    end
`else
    assign lock_release = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q      <= '0;
            dec_q     <= 1'b0;
            sd_q      <= '0;
            scan_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '0;
            state_q   <= FREE;
        end else begin
            sc_q      <= sc_d;
            dec_q     <= dec_d;
            sd_q      <= sd_d;
            scan_q    <= scan_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
        end
    end

    assign dec  = dec_q;
    assign scan = scan_q;
    assign we   = state_q[1];
    assign ns   = state_q[0];
    assign c1   = deb_q[IN_C1];
    assign c0   = deb_q[IN_C0];

endmodule

// File: tb/tb_tl_input_stage.sv
// tb_tl_input_stage: table-driven checks of tl_input_stage with small divider/debounce parameters.
module tb_tl_input_stage;

    localparam int unsigned CLK_DIV_SEC = 20;
    localparam int unsigned SCAN_DIV    = 4;
    localparam int unsigned DEB_CYCLES  = 3;
    localparam int unsigned LOCK_S      = 2;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_we = 1'b0;
    logic btn_ns = 1'b0;
    logic sw_c1  = 1'b0;
    logic sw_c0  = 1'b0;
    logic dec, scan, we, ns, c1, c0;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    bit          track       = 1'b0;

    typedef struct {
        string       name;
        logic        bwe;
        logic        bns;
        logic        s1;
        logic        s0;
        int unsigned cycles;
        logic [3:0]  exp;   // {we, ns, c1, c0}
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    tl_input_stage #(
        .CLK_DIV_SEC (CLK_DIV_SEC),
        .SCAN_DIV    (SCAN_DIV),
        .DEB_CYCLES  (DEB_CYCLES),
        .LOCK_S      (LOCK_S)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_we (btn_we),
        .btn_ns (btn_ns),
        .sw_c1  (sw_c1),
        .sw_c0  (sw_c0),
        .dec    (dec),
        .scan   (scan),
        .we     (we),
        .ns     (ns),
        .c1     (c1),
        .c0     (c0)
    );

    function automatic vec_t mk(input string n, input logic bwe, input logic bns,
                                input logic s1, input logic s0, input int unsigned cy,
                                input logic [3:0] e);
        vec_t v;
        v.name   = n;
        v.bwe    = bwe;
        v.bns    = bns;
        v.s1     = s1;
        v.s0     = s0;
        v.cycles = cy;
        v.exp    = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advances one clock; while tracking, cyc counts edges since the last rst release.
    task automatic tick();
        logic exp_dec, exp_scan;
        @(posedge clk);
        #1;
        if (track) begin
            cyc++;
            exp_dec  = ((cyc % CLK_DIV_SEC) >= (CLK_DIV_SEC / 2));
            exp_scan = (((cyc / SCAN_DIV) % 2) == 1);
            check("dec_scan", {6'b0, dec, scan}, {6'b0, exp_dec, exp_scan});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_v;
        int unsigned entry;
        int unsigned rel;

        tbl.push_back(mk("glitch_we_on",   1'b1, 1'b0, 1'b0, 1'b0, 2, 4'b0000));
        tbl.push_back(mk("glitch_we_off",  1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b0000));
        tbl.push_back(mk("we_hold_4",      1'b1, 1'b0, 1'b0, 1'b0, 4, 4'b0000));
        tbl.push_back(mk("we_hold_5",      1'b1, 1'b0, 1'b0, 1'b0, 1, 4'b1000));
        tbl.push_back(mk("we_hold_10",     1'b1, 1'b0, 1'b0, 1'b0, 5, 4'b1000));
        tbl.push_back(mk("we_release",     1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b1000));
        tbl.push_back(mk("ns_from_we",     1'b0, 1'b1, 1'b0, 1'b0, 6, 4'b0100));
        tbl.push_back(mk("ns_release",     1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b0100));
        tbl.push_back(mk("ns_to_free",     1'b0, 1'b1, 1'b0, 1'b0, 6, 4'b0000));
        tbl.push_back(mk("ns_release2",    1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b0000));
        tbl.push_back(mk("both_pressed",   1'b1, 1'b1, 1'b0, 1'b0, 6, 4'b0000));
        tbl.push_back(mk("both_release",   1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b0000));
        tbl.push_back(mk("ns_lock",        1'b0, 1'b1, 1'b0, 1'b0, 6, 4'b0100));
        tbl.push_back(mk("ns_lock_rel",    1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b0100));
        tbl.push_back(mk("we_from_ns",     1'b1, 1'b0, 1'b0, 1'b0, 6, 4'b1000));
        tbl.push_back(mk("we_from_ns_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b1000));
        tbl.push_back(mk("we_to_free",     1'b1, 1'b0, 1'b0, 1'b0, 6, 4'b0000));
        tbl.push_back(mk("we_to_free_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8, 4'b0000));
        tbl.push_back(mk("sw_hold_4",      1'b0, 1'b0, 1'b1, 1'b1, 4, 4'b0000));
        tbl.push_back(mk("sw_hold_5",      1'b0, 1'b0, 1'b1, 1'b1, 1, 4'b0011));
        tbl.push_back(mk("c0_toggle_1",    1'b0, 1'b0, 1'b1, 1'b0, 2, 4'b0011));
        tbl.push_back(mk("c0_toggle_2",    1'b0, 1'b0, 1'b1, 1'b1, 2, 4'b0011));
        tbl.push_back(mk("c0_toggle_3",    1'b0, 1'b0, 1'b1, 1'b0, 2, 4'b0011));
        tbl.push_back(mk("c0_toggle_4",    1'b0, 1'b0, 1'b1, 1'b1, 2, 4'b0011));
        tbl.push_back(mk("c0_low",         1'b0, 1'b0, 1'b1, 1'b0, 5, 4'b0010));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {2'b0, dec, scan, we, ns, c1, c0}, 8'h00);

        rst   = 1'b0;
        cyc   = 0;
        track = 1'b1;
        repeat (60) tick();

        foreach (tbl[i]) begin
            btn_we = tbl[i].bwe;
            btn_ns = tbl[i].bns;
            sw_c1  = tbl[i].s1;
            sw_c0  = tbl[i].s0;
            sb.push_back(tbl[i].exp);
            repeat (tbl[i].cycles) tick();
            exp_v = sb.pop_front();
            check(tbl[i].name, {4'b0, we, ns, c1, c0}, {4'b0, exp_v});
        end

        // Lock hold / timed release
        btn_we = 1'b1;
        repeat (5) tick();
        check("lock_we", {6'b0, we, ns}, 8'b10);
        entry  = cyc;
        btn_we = 1'b0;
`ifdef TL_AUTO_RELEASE_EN
        rel = (entry / CLK_DIV_SEC + 1) * CLK_DIV_SEC + CLK_DIV_SEC;
        while (cyc < rel - 1) tick();
        check("auto_hold", {6'b0, we, ns}, 8'b10);
        tick();
        check("auto_release", {6'b0, we, ns}, 8'b00);
`else
        rel = entry + 200;
        while (cyc < rel) begin
            tick();
            check("lock_hold", {6'b0, we, ns}, 8'b10);
        end
`endif

        // Reset mid-second with a lock held, button still pressed across the release
        rst   = 1'b1;
        track = 1'b0;
        repeat (2) tick();
        rst    = 1'b0;
        cyc    = 0;
        track  = 1'b1;
        btn_we = 1'b1;
        repeat (15) tick();
        check("pre_rst_we", {6'b0, we, ns}, 8'b10);
        rst = 1'b1;
        #1;
        check("async_rst", {4'b0, dec, scan, we, ns}, 8'h00);
        track = 1'b0;
        repeat (3) tick();
        rst   = 1'b0;
        cyc   = 0;
        track = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("rst_we_relock", {7'b0, we}, {7'b0, (k >= 5) ? 1'b1 : 1'b0});
        end
        btn_we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
